// File: rtl/lcd_line_arbiter_pkg.sv
// lcd_pkg: shared types and constants for the two-client LCD line arbiter.
//   state_t      - arbiter FSM state encoding
//   LCD_CHAR_W   - bits per character code
//   LCD_COL_W    - width of the LCD column index
//   LCD_COLS_MAX - widest line the column index can address
package lcd_pkg;

    localparam int LCD_CHAR_W   = 8;
    localparam int LCD_COL_W    = 4;
    localparam int LCD_COLS_MAX = 16;

    typedef enum logic [2:0] {
        S_INIT   = 3'd0,
        S_IDLE   = 3'd1,
        S_WRITE  = 3'd2,
        S_UPDATE = 3'd3,
        S_WAIT   = 3'd4
    } state_t;

endpackage

// File: rtl/lcd_line_arbiter_if.sv
// lcd_line_arbiter_if: bundle of client requests, line data and the shared
// LCD write port.
//   slave  - arbiter view: takes req/line0/line1/lcd_busy, drives grants,
//            completions and the LCD write port.
//   master - client/LCD-driver view of the same signals.
interface lcd_line_arbiter_if
    import lcd_pkg::*;
#(
    parameter int NCOL = 10
) ();

    logic [1:0]                 req;
    logic [LCD_CHAR_W*NCOL-1:0] line0;
    logic [LCD_CHAR_W*NCOL-1:0] line1;
    logic [1:0]                 gnt;
    logic [1:0]                 done;
    logic                       lcd_row;
    logic [LCD_COL_W-1:0]       lcd_col;
    logic [LCD_CHAR_W-1:0]      lcd_char;
    logic                       lcd_we;
    logic                       update;
    logic                       lcd_busy;

    modport slave (
        input  req, line0, line1, lcd_busy,
        output gnt, done, lcd_row, lcd_col, lcd_char, lcd_we, update
    );

    modport master (
        output req, line0, line1, lcd_busy,
        input  gnt, done, lcd_row, lcd_col, lcd_char, lcd_we, update
    );

endinterface

// File: rtl/lcd_line_arbiter_rr_arb2.sv
// rr_arb2: combinational two-way round-robin pick.
//   req  - request vector, bit i = client i
//   last - index of the client served most recently
//   win  - one-hot winner, zero when nobody requests
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic [1:0] win
);

    always_comb begin
        win = req;
        // On a tie the client that was not served last goes next.
        if (req == 2'b11) begin
            win = last ? 2'b01 : 2'b10;
        end
    end

endmodule

// File: rtl/lcd_line_arbiter.sv
// lcd_line_arbiter: shares one character-LCD write port between two
// line-writer clients. A granted client's line is latched, written out one
// character per cycle on its own row, followed by an update strobe; the block
// then waits for the LCD to go idle and pulses done for that client.
//   CLK  - system clock, rising edge
//   RST  - asynchronous active-high reset
//   bus  - slave side of lcd_line_arbiter_if (requests, lines, LCD port)
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_INIT   | after reset, wait for the LCD driver to report idle
// S_IDLE   | arbitrate; grant when someone requests and LCD is idle
// S_WRITE  | one character per cycle from the latched line
// S_UPDATE | single-cycle display refresh strobe
// S_WAIT   | guard cycle, then wait for idle LCD and report done
module lcd_line_arbiter
    import lcd_pkg::*;
#(
    parameter int NCOL = 10
) (
    input logic               CLK,
    input logic               RST,
    lcd_line_arbiter_if.slave bus
);

    localparam int LINE_W = LCD_CHAR_W * NCOL;
    localparam int PAD_W  = LCD_CHAR_W * LCD_COLS_MAX;
    localparam logic [LCD_COL_W-1:0] LAST_COL = LCD_COL_W'(NCOL - 1);

    state_t                state_q, state_d;
    logic [LINE_W-1:0]     line_q, line_d;
    logic [LCD_COL_W-1:0]  col_q, col_d;
    logic [1:0]            gnt_q, gnt_d;
    logic [1:0]            done_q, done_d;
    logic                  row_q, row_d;
    logic [LCD_CHAR_W-1:0] char_q, char_d;
    logic                  we_q, we_d;
    logic                  update_q, update_d;
    logic                  guard_q, guard_d;
    logic                  last_q, last_d;

    logic [1:0]            win;
    logic [LINE_W-1:0]     win_line;
    logic [PAD_W-1:0]      line_pad;
    logic [LCD_COL_W-1:0]  nxt_col;

    rr_arb2 u_arb (
        .req  (bus.req),
        .last (last_q),
        .win  (win)
    );

    assign win_line = win[1] ? bus.line1 : bus.line0;

    // Padding the latched line to the full column range keeps the variable
    // character select in bounds for every legal NCOL.
    assign line_pad = PAD_W'(line_q);
    assign nxt_col  = col_q + 1'b1;

    always_comb begin
        state_d  = state_q;
        line_d   = line_q;
        col_d    = col_q;
        gnt_d    = gnt_q;
        done_d   = 2'b00;
        row_d    = row_q;
        char_d   = char_q;
        we_d     = 1'b0;
        update_d = 1'b0;
        guard_d  = guard_q;
        last_d   = last_q;

        case (state_q)
            S_INIT: begin
                if (!bus.lcd_busy) begin
                    state_d = S_IDLE;
                end
            end

            S_IDLE: begin
                if ((bus.req != 2'b00) && !bus.lcd_busy) begin
                    state_d = S_WRITE;
                    gnt_d   = win;
                    line_d  = win_line;
                    col_d   = '0;
                    row_d   = win[1];
                    // First character comes straight from the client line so
                    // the write can go out on the cycle after the grant.
                    char_d  = win_line[LCD_CHAR_W-1:0];
                    we_d    = 1'b1;
                end
            end

            S_WRITE: begin
                if (col_q == LAST_COL) begin
                    state_d  = S_UPDATE;
                    update_d = 1'b1;
                end else begin
                    col_d  = nxt_col;
                    char_d = line_pad[{nxt_col, 3'b000} +: LCD_CHAR_W];
                    we_d   = 1'b1;
                end
            end

            S_UPDATE: begin
                state_d = S_WAIT;
                guard_d = 1'b1;
            end

            S_WAIT: begin
                // The driver may not have raised busy yet right after the
                // update strobe, so its first sample is ignored.
                if (guard_q) begin
                    guard_d = 1'b0;
                end else if (!bus.lcd_busy) begin
                    done_d  = gnt_q;
                    gnt_d   = 2'b00;
                    last_d  = gnt_q[1];
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_INIT;
            end
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= S_INIT;
            line_q   <= '0;
            col_q    <= '0;
            gnt_q    <= 2'b00;
            done_q   <= 2'b00;
            row_q    <= 1'b0;
            char_q   <= '0;
            we_q     <= 1'b0;
            update_q <= 1'b0;
            guard_q  <= 1'b0;
            last_q   <= 1'b1;
        end else begin
            state_q  <= state_d;
            line_q   <= line_d;
            col_q    <= col_d;
            gnt_q    <= gnt_d;
            done_q   <= done_d;
            row_q    <= row_d;
            char_q   <= char_d;
            we_q     <= we_d;
            update_q <= update_d;
            guard_q  <= guard_d;
            last_q   <= last_d;
        end
    end

    assign bus.gnt      = gnt_q;
    assign bus.done     = done_q;
    assign bus.lcd_row  = row_q;
    assign bus.lcd_col  = col_q;
    assign bus.lcd_char = char_q;
    assign bus.lcd_we   = we_q;
    assign bus.update   = update_q;

endmodule

// File: tb/tb_lcd_line_arbiter.sv
module tb_lcd_line_arbiter;
    import lcd_pkg::*;

    localparam int NCOL = 10;

    logic clk  = 1'b0;
    logic rst  = 1'b1;
    logic rst1 = 1'b1;

    always #5 clk = ~clk;

    lcd_line_arbiter_if #(.NCOL(NCOL)) bus ();
    lcd_line_arbiter_if #(.NCOL(1))    bus1 ();

    lcd_line_arbiter #(.NCOL(NCOL)) dut (
        .CLK (clk),
        .RST (rst),
        .bus (bus)
    );

    lcd_line_arbiter #(.NCOL(1)) dut1 (
        .CLK (clk),
        .RST (rst1),
        .bus (bus1)
    );

    int   checks   = 0;
    int   failures = 0;
    logic last_srv = 1'b1;   // reference model: client served most recently

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_idle_outs(input string tag);
        chk({tag, "_gnt"},  bus.gnt,      2'b00);
        chk({tag, "_done"}, bus.done,     2'b00);
        chk({tag, "_we"},   bus.lcd_we,   1'b0);
        chk({tag, "_upd"},  bus.update,   1'b0);
    endtask

    task automatic chk_reset_outs(input string tag);
        chk_idle_outs(tag);
        chk({tag, "_row"},  bus.lcd_row,  1'b0);
        chk({tag, "_col"},  bus.lcd_col,  4'd0);
        chk({tag, "_char"}, bus.lcd_char, 8'd0);
    endtask

    // Winner according to the arbitration rules: a sole requester wins,
    // on a tie the client other than the last served one wins.
    function automatic logic [1:0] pick(input logic [1:0] r);
        if (r == 2'b01 || r == 2'b10) return r;
        return (last_srv == 1'b0) ? 2'b10 : 2'b01;
    endfunction

    task automatic rand_lines();
        for (int k = 0; k < NCOL; k++) begin
            bus.line0[8*k +: 8] = 8'($urandom_range(32, 126));
            bus.line1[8*k +: 8] = 8'($urandom_range(32, 126));
        end
    endtask

    // Called in a cycle where the DUT is idle. Busy is held high for
    // busy_len cycles starting with the update cycle; drop_col >= 0 drops the
    // winner's request and scrambles both lines during that column.
    task automatic burst(input logic [1:0] r, input int busy_len, input int drop_col);
        logic [1:0]        w1h;
        logic [8*NCOL-1:0] ln;
        int                done_off;
        logic              got;
        w1h = pick(r);
        ln  = w1h[1] ? bus.line1 : bus.line0;
        bus.req      = r;
        bus.lcd_busy = 1'b0;
        step();
        for (int k = 0; k < NCOL; k++) begin
            chk("wr_gnt",  bus.gnt,      w1h);
            chk("wr_we",   bus.lcd_we,   1'b1);
            chk("wr_col",  bus.lcd_col,  k);
            chk("wr_row",  bus.lcd_row,  w1h[1]);
            chk("wr_char", bus.lcd_char, ln[8*k +: 8]);
            chk("wr_upd",  bus.update,   1'b0);
            chk("wr_done", bus.done,     2'b00);
            if (k == drop_col) begin
                bus.req   = bus.req & ~w1h;
                bus.line0 = ~bus.line0;
                bus.line1 = ~bus.line1;
            end
            step();
        end
        chk("upd_pulse", bus.update, 1'b1);
        chk("upd_we",    bus.lcd_we, 1'b0);
        chk("upd_gnt",   bus.gnt,    w1h);
        bus.lcd_busy = (busy_len > 0);
        // busy is first honoured two cycles after the update cycle; done
        // follows one cycle after the first low sample from then on.
        done_off = ((busy_len > 2) ? busy_len : 2) + 1;
        got = 1'b0;
        for (int c = 1; c <= busy_len + 8 && !got; c++) begin
            step();
            if (c < done_off) begin
                chk("wait_done", bus.done,   2'b00);
                chk("wait_gnt",  bus.gnt,    w1h);
                chk("wait_we",   bus.lcd_we, 1'b0);
            end else begin
                chk("done_pulse", bus.done,   w1h);
                chk("done_gnt",   bus.gnt,    2'b00);
                chk("done_we",    bus.lcd_we, 1'b0);
                got = 1'b1;
            end
            bus.lcd_busy = (c < busy_len);
        end
        chk("done_seen", got, 1'b1);
        last_srv = w1h[1];
    endtask

    initial begin
        string      hello;
        logic [1:0] r;
        int         dc;

        bus.req = 2'b00;  bus.line0 = '0; bus.line1 = '0; bus.lcd_busy = 1'b1;
        bus1.req = 2'b00; bus1.line0 = '0; bus1.line1 = '0; bus1.lcd_busy = 1'b1;

        // Reset values
        step();
        step();
        chk_reset_outs("rst");

        // Stuck in init while the LCD is busy
        rst = 1'b0;
        bus.req = 2'b01;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle_outs("init_busy");
        end
        bus.req = 2'b00;
        bus.lcd_busy = 1'b0;
        step();

        // Single client with a known line
        hello = "HELLO WRLD";
        for (int k = 0; k < NCOL; k++) bus.line0[8*k +: 8] = hello[k];
        for (int k = 0; k < NCOL; k++) bus.line1[8*k +: 8] = 8'($urandom_range(32, 126));
        burst(2'b01, 5, -1);
        bus.req = 2'b00;
        step();
        chk_idle_outs("after_single");

        // Tie and rotation with req held at 11
        for (int i = 0; i < 3; i++) begin
            rand_lines();
            burst(2'b11, int'($urandom_range(0, 6)), -1);
        end

        // Request drop and line change mid-burst
        rand_lines();
        burst(2'b10, 3, 3);

        // Busy gating in idle, then a guard-cycle check with busy low
        bus.req = 2'b01;
        bus.lcd_busy = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_idle_outs("idle_busy");
        end
        rand_lines();
        burst(2'b01, 0, -1);

        // Randomized bursts, sometimes separated by idle gaps
        for (int i = 0; i < 10; i++) begin
            r = 2'($urandom_range(1, 3));
            dc = int'($urandom_range(0, NCOL + 3)) - 1;
            if (dc >= NCOL) dc = -1;
            if ($urandom_range(0, 2) == 0) begin
                bus.req = 2'b00;
                step();
                chk_idle_outs("gap");
            end
            rand_lines();
            burst(r, int'($urandom_range(0, 7)), dc);
        end

        // Reset in the middle of a burst
        rand_lines();
        bus.req = 2'b01;
        bus.lcd_busy = 1'b0;
        for (int i = 0; i < 6; i++) step();
        chk("mid_col", bus.lcd_col, 4'd5);
        rst = 1'b1;
        #1;
        chk_reset_outs("rst_mid");
        for (int i = 0; i < 2; i++) begin
            step();
            chk_reset_outs("rst_hold");
        end
        rst = 1'b0;
        last_srv = 1'b1;
        bus.req = 2'b00;
        step();
        rand_lines();
        burst(2'b10, 2, -1);

        // Single-column build: write, update, guard, then done at N+5 offset
        rst1 = 1'b0;
        bus1.lcd_busy = 1'b0;
        step();
        bus1.line0 = 8'h41;
        bus1.line1 = 8'h5a;
        bus1.req = 2'b01;
        step();
        chk("n1_gnt",  bus1.gnt,      2'b01);
        chk("n1_we",   bus1.lcd_we,   1'b1);
        chk("n1_col",  bus1.lcd_col,  4'd0);
        chk("n1_char", bus1.lcd_char, 8'h41);
        chk("n1_row",  bus1.lcd_row,  1'b0);
        bus1.req = 2'b00;
        step();
        chk("n1_upd",    bus1.update, 1'b1);
        chk("n1_upd_we", bus1.lcd_we, 1'b0);
        step();
        chk("n1_guard_done", bus1.done,   2'b00);
        chk("n1_guard_upd",  bus1.update, 1'b0);
        step();
        chk("n1_wait_done", bus1.done, 2'b00);
        chk("n1_wait_gnt",  bus1.gnt,  2'b01);
        step();
        chk("n1_done",     bus1.done, 2'b01);
        chk("n1_done_gnt", bus1.gnt,  2'b00);
        step();
        chk("n1_done_once", bus1.done, 2'b00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
